// File: rtl/vga_blit_pkg.sv
// rtl/vga_blit_pkg.sv - address map, FSM states and header helper for vga_blit_master
package vga_blit_pkg;

  localparam logic [18:0] REG_X      = 19'd0;
  localparam logic [18:0] REG_Y      = 19'd1;
  localparam logic [18:0] REG_W      = 19'd2;
  localparam logic [18:0] REG_H      = 19'd3;
  localparam logic [18:0] REG_COMMIT = 19'd4;
  localparam logic [18:0] PIX_BASE   = 19'd6;

  localparam int VGA_COLS = 640;
  localparam int VGA_ROWS = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_HDR,
    ST_PIX,
    ST_FIN
  } state_e;

  // Header word for slot idx; the commit slot carries zero.
  function automatic logic [15:0] hdr_word(input logic [2:0] idx,
                                           input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] w, input logic [15:0] h);
    case (idx)
      3'd0:    hdr_word = x;
      3'd1:    hdr_word = y;
      3'd2:    hdr_word = w;
      3'd3:    hdr_word = h;
      default: hdr_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/vga_blit_master.sv
// rtl/vga_blit_master.sv - Avalon-MM write master feeding the VGA box-translation slave
// Optional command checking (zero/oversize boxes) under `BLIT_CMD_CHECK_EN.
module vga_blit_master #(
  parameter int MAX_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [15:0] cmd_w,
  input  logic [15:0] cmd_h,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  output logic [18:0] avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic [1:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err
);
  import vga_blit_pkg::*;

  localparam int RW = $clog2(MAX_PIXELS + 1);

  state_e         state_q, state_d;
  logic [15:0]    x_q, y_q, w_q, h_q;
  logic [31:0]    count_q, count_d;
  logic [RW-1:0]  remaining_q, remaining_d;
  logic [2:0]     hdr_idx_q, hdr_idx_d;
  logic [18:0]    addr_q, addr_d;
  logic [18:0]    pix_addr_q, pix_addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           write_q, write_d;
  logic           err_q, err_d;
  logic           cmd_ready_q;

  logic           cmd_fire;
  logic           accept;
  logic           pix_fire;
  logic [31:0]    product;
  logic           reject;
  logic [2:0]     next_idx;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign accept   = write_q && !avm_waitrequest;
  assign pix_fire = pix_valid && pix_ready;
  assign product  = 32'(w_q) * 32'(h_q);
  assign next_idx = hdr_idx_q + 3'd1;

`ifdef BLIT_CMD_CHECK_EN
  assign reject = (w_q == 16'd0) || (h_q == 16'd0) || (product > 32'(MAX_PIXELS));
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire) state_d = ST_CALC;
      ST_CALC: state_d = reject ? ST_IDLE : ST_HDR;
      ST_HDR:  if (accept && hdr_idx_q == 3'd4) state_d = (count_q == 32'd0) ? ST_FIN : ST_PIX;
      ST_PIX:  if (accept && remaining_q == '0) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    remaining_d = remaining_q;
    hdr_idx_d   = hdr_idx_q;
    addr_d      = addr_q;
    pix_addr_d  = pix_addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    err_d       = 1'b0;
    pix_ready   = (state_q == ST_PIX) && (!write_q || !avm_waitrequest) && (remaining_q != '0);
    case (state_q)
      ST_CALC: begin
        count_d = product;
        err_d   = reject;
        if (!reject) begin
          write_d   = 1'b1;
          addr_d    = REG_X;
          wdata_d   = x_q;
          hdr_idx_d = 3'd0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdr_idx_q != 3'd4) begin
            hdr_idx_d = next_idx;
            addr_d    = 19'(next_idx);
            wdata_d   = hdr_word(next_idx, x_q, y_q, w_q, h_q);
          end else begin
            write_d     = 1'b0;
            remaining_d = count_q[RW-1:0];
            pix_addr_d  = PIX_BASE;
          end
        end
      end
      ST_PIX: begin
        // A new beat may replace a write in the same cycle it is accepted.
        if (pix_fire) begin
          write_d     = 1'b1;
          addr_d      = pix_addr_q;
          wdata_d     = pix_data;
          pix_addr_d  = pix_addr_q + 19'd1;
          remaining_d = remaining_q - 1'b1;
        end else if (accept) begin
          write_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      hdr_idx_q   <= '0;
      addr_q      <= '0;
      pix_addr_q  <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        x_q <= cmd_x;
        y_q <= cmd_y;
        w_q <= cmd_w;
        h_q <= cmd_h;
      end
      count_q     <= count_d;
      remaining_q <= remaining_d;
      hdr_idx_q   <= hdr_idx_d;
      addr_q      <= addr_d;
      pix_addr_q  <= pix_addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 2'b11;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FIN);
  assign err            = err_q;

endmodule
